e_mat_mult: RTL and testbench

Element-wise (Hadamard) multiplier for two 3x3 matrices of unsigned integers, packed row-major on flat buses. Each of the nine result elements is the product of the corresponding input elements, reduced to element width by wrap or saturation. It is a single-stage registered datapath used as an arithmetic leaf in the matrix-processing pipeline. A valid strobe accompanies each input and output.

---
 rtl/e_mat_mult.sv | 59 +++++
 tb/tb_e_mat_mult.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/e_mat_mult.sv
// Element-wise 3x3 matrix multiplier, one registered stage.
// Each product wraps or saturates to W bits, and an overflow flag is kept per element.
module e_mat_mult #(
  parameter int W        = 8,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [9*W-1:0] A,
  input  logic [9*W-1:0] B,
  output logic           out_valid,
  output logic [9*W-1:0] Res,
  output logic [8:0]     ovf
);

  logic [9*W-1:0] res_d;
  logic [8:0]     ovf_d;
  logic [2*W-1:0] prod;
  logic [W-1:0]   ea;
  logic [W-1:0]   eb;
  logic           hi;

  // Element 0 sits in the MSB slice, and its flag sits in ovf[8]
  always_comb begin
    res_d = '0;
    ovf_d = '0;
    prod  = '0;
    ea    = '0;
    eb    = '0;
    hi    = 1'b0;
    for (int k = 0; k < 9; k++) begin
      ea   = A[9*W-1-k*W -: W];
      eb   = B[9*W-1-k*W -: W];
      prod = {{W{1'b0}}, ea} * {{W{1'b0}}, eb};
      hi   = |prod[2*W-1:W];
      ovf_d[8-k] = hi;
      if (SATURATE != 0 && hi)
        res_d[9*W-1-k*W -: W] = {W{1'b1}};
      else
        res_d[9*W-1-k*W -: W] = prod[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Res       <= '0;
      ovf       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Res <= res_d;
        ovf <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_e_mat_mult.sv
// Bench for e_mat_mult: runs the wrap and saturate builds side by side.
// Uses table vectors, hand-written reset sequences and randomized traffic.
module tb_e_mat_mult;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [71:0]   A = '0;
  logic [71:0]   B = '0;
  logic          ov_w, ov_s;
  logic [71:0]   res_w, res_s;
  logic [8:0]    f_w, f_s;

  e_mat_mult #(.W(W), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(A), .B(B),
    .out_valid(ov_w), .Res(res_w), .ovf(f_w)
  );

  e_mat_mult #(.W(W), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(A), .B(B),
    .out_valid(ov_s), .Res(res_s), .ovf(f_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected outputs held by the reference model
  logic        m_v;
  logic [71:0] m_rw, m_rs;
  logic [8:0]  m_f;

  typedef struct {
    string       nm;
    logic [71:0] a;
    logic [71:0] b;
    logic [71:0] rw;
    logic [71:0] rs;
    logic [8:0]  f;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic v,
                         input logic [71:0] rw, input logic [71:0] rs,
                         input logic [8:0] f);
    chk({nm, ".valid_w"}, {71'd0, ov_w}, {71'd0, v});
    chk({nm, ".valid_s"}, {71'd0, ov_s}, {71'd0, v});
    chk({nm, ".res_w"}, res_w, rw);
    chk({nm, ".res_s"}, res_s, rs);
    chk({nm, ".ovf_w"}, {63'd0, f_w}, {63'd0, f});
    chk({nm, ".ovf_s"}, {63'd0, f_s}, {63'd0, f});
  endtask

  // Reference model: unpack to integers, multiply, then reduce
  task automatic model(input logic [71:0] a, input logic [71:0] b,
                       output logic [71:0] rw, output logic [71:0] rs,
                       output logic [8:0] f);
    int ea[9], eb[9], p;
    for (int k = 0; k < 9; k++) begin
      ea[k] = int'(a[71-8*k -: 8]);
      eb[k] = int'(b[71-8*k -: 8]);
    end
    rw = '0; rs = '0; f = '0;
    for (int k = 0; k < 9; k++) begin
      p = ea[k] * eb[k];
      rw[71-8*k -: 8] = 8'(p % 256);
      rs[71-8*k -: 8] = (p > 255) ? 8'd255 : 8'(p);
      f[8-k] = (p > 255);
    end
  endtask

  task automatic model_reset();
    m_v = 1'b0; m_rw = '0; m_rs = '0; m_f = '0;
  endtask

  // Drive one cycle at negedge, then check the model at posedge+1
  task automatic step(input string nm, input logic v,
                      input logic [71:0] a, input logic [71:0] b);
    @(negedge clk);
    in_valid = v; A = a; B = b;
    if (v) model(a, b, m_rw, m_rs, m_f);
    m_v = v;
    @(posedge clk);
    #1;
    chk_all(nm, m_v, m_rw, m_rs, m_f);
  endtask

  task automatic setv(input int i, input string nm,
                      input logic [71:0] a, input logic [71:0] b,
                      input logic [71:0] rw, input logic [71:0] rs,
                      input logic [8:0] f);
    tbl[i].nm = nm; tbl[i].a = a; tbl[i].b = b;
    tbl[i].rw = rw; tbl[i].rs = rs; tbl[i].f = f;
  endtask

  function automatic logic [7:0] rnd_el();
    case ($urandom % 3)
      0: return 8'($urandom_range(255, 0));
      1: return 8'($urandom_range(15, 0));
      default: return 8'($urandom_range(255, 240));
    endcase
  endfunction

  logic [71:0] nom_a, nom_b, nom_r, wr_a, wr_b;

  initial begin
    nom_a = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    nom_b = {8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
    nom_r = {8'd10, 8'd22, 8'd36, 8'd52, 8'd70, 8'd90, 8'd112, 8'd136, 8'd162};
    wr_a  = {8'd16, 56'd0, 8'd255};
    wr_b  = {8'd17, 56'd0, 8'd255};

    setv(0, "zeros", '0, '0, '0, '0, 9'd0);
    setv(1, "ones", {9{8'd1}}, {9{8'd1}}, {9{8'd1}}, {9{8'd1}}, 9'd0);
    setv(2, "nominal", nom_a, nom_b, nom_r, nom_r, 9'd0);
    setv(3, "wrap_sat", wr_a, wr_b,
         {8'd16, 56'd0, 8'd1}, {8'd255, 56'd0, 8'd255}, 9'b100000001);
    setv(4, "boundary",
         {8'd255, 8'd16, 8'd15, 40'd0, 8'd128},
         {8'd1, 8'd16, 8'd17, 40'd0, 8'd2},
         {8'd255, 8'd0, 8'd255, 40'd0, 8'd0},
         {8'd255, 8'd255, 8'd255, 40'd0, 8'd255},
         9'b010000001);
    setv(5, "maxes", {9{8'd255}}, {9{8'd255}},
         {9{8'd1}}, {9{8'd255}}, 9'h1ff);

    // Reset held with valid, nonzero operands presented
    rst_n = 1'b0; in_valid = 1'b1;
    A = {9{8'h3c}}; B = {9{8'h5a}};
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all("reset_hold", 1'b0, '0, '0, 9'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    // Table: back-to-back stream of valid vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; A = tbl[i].a; B = tbl[i].b;
      @(posedge clk);
      #1;
      chk_all(tbl[i].nm, 1'b1, tbl[i].rw, tbl[i].rs, tbl[i].f);
    end
    model(tbl[5].a, tbl[5].b, m_rw, m_rs, m_f);
    step("idle_hold", 1'b0, {9{8'h77}}, {9{8'h99}});
    chk_all("idle_hold_tbl", 1'b0, tbl[5].rw, tbl[5].rs, tbl[5].f);

    // Asynchronous reset taken between clock edges
    step("pre_async", 1'b1, nom_a, nom_b);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 1'b0, '0, '0, 9'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    // Mid-stream reset: a captured result must be discarded
    @(negedge clk);
    in_valid = 1'b1; A = wr_a; B = wr_b;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all("mid_rst", 1'b0, '0, '0, 9'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    step("post_rst0", 1'b0, wr_a, wr_b);
    step("post_rst1", 1'b0, nom_a, nom_b);
    step("post_rst_new", 1'b1, wr_a, wr_b);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [71:0] ra, rb;
      for (int k = 0; k < 9; k++) begin
        ra[71-8*k -: 8] = rnd_el();
        rb[71-8*k -: 8] = rnd_el();
      end
      step("random", ($urandom % 4) != 0, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
